// File: rtl/mem_ctrl_if.sv
// Bus bundle for mem_ctrl: core-side fetch/LSQ handshakes plus the byte-wide RAM/IO port.
// The controller uses the slave view; whatever drives the requests and the RAM uses master.
interface mem_ctrl_if;
  logic        ena;
  logic        in_rollback;
  logic        in_fetch_ena;
  logic [31:0] in_fetch_addr;
  logic        out_fetch_ready;
  logic [31:0] out_fetch_data;
  logic        in_lsq_ena;
  logic        in_lsq_iswrite;
  logic [31:0] in_lsq_addr;
  logic [2:0]  in_lsq_size;
  logic [31:0] in_lsq_write_data;
  logic        out_lsq_ready;
  logic [31:0] out_lsq_data;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  ena, in_rollback, in_fetch_ena, in_fetch_addr,
    input  in_lsq_ena, in_lsq_iswrite, in_lsq_addr, in_lsq_size, in_lsq_write_data,
    input  io_buffer_full, mem_din,
    output out_fetch_ready, out_fetch_data, out_lsq_ready, out_lsq_data,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output ena, in_rollback, in_fetch_ena, in_fetch_addr,
    output in_lsq_ena, in_lsq_iswrite, in_lsq_addr, in_lsq_size, in_lsq_write_data,
    output io_buffer_full, mem_din,
    input  out_fetch_ready, out_fetch_data, out_lsq_ready, out_lsq_data,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch and LSQ requests onto a byte-wide RAM/IO bus,
// serialising each access into byte transactions and assembling little-endian results.
module mem_ctrl #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, WR_WAIT} state_e;

  state_e      state_q;
  logic        fetch_pend_q;
  logic [31:0] fetch_addr_q;
  logic        lsq_pend_q;
  logic        lsq_wr_q;
  logic [31:0] lsq_addr_q;
  logic [31:0] lsq_wdata_q;
  logic [2:0]  lsq_size_q;
  logic        cur_fetch_q;
  logic [31:0] base_q;
  logic [31:0] wdata_q;
  logic [31:0] asm_q;
  logic [1:0]  cnt_q;
  logic [1:0]  last_q;
  logic        reissue_q;
  logic        mem_wr_q;
  logic [7:0]  mem_dout_q;
  logic [31:0] mem_a_q;
  logic        fetch_ready_q;
  logic        lsq_ready_q;
  logic [31:0] fetch_data_q;
  logic [31:0] lsq_data_q;

  logic [1:0]  cnt_d;
  logic [31:0] cur_addr_d;
  logic [31:0] next_addr_d;
  logic [7:0]  cur_byte_d;
  logic [7:0]  next_byte_d;
  logic [31:0] asm_d;
  logic        done_d;
  logic        fetch_free_d;
  logic        lsq_free_d;

  function automatic logic [1:0] size_last(input logic [2:0] size);
    case (size)
      3'd1:    size_last = 2'd0;
      3'd2:    size_last = 2'd1;
      default: size_last = 2'd3;
    endcase
  endfunction

  function automatic logic is_io(input logic [31:0] addr);
    is_io = (addr[17:16] == IO_ADDR_HI);
  endfunction

  assign cnt_d       = cnt_q + 2'd1;
  assign cur_addr_d  = base_q + {30'b0, cnt_q};
  assign next_addr_d = base_q + {30'b0, cnt_d};
  assign cur_byte_d  = wdata_q[8*cnt_q +: 8];
  assign next_byte_d = wdata_q[8*cnt_d +: 8];
  assign asm_d       = asm_q | ({24'b0, bus.mem_din} << {cnt_q, 3'b000});
  // A request finishing on this edge frees its slot, so a same-edge pulse is latched.
  assign done_d       = (state_q == RD || state_q == WR) && !reissue_q && (cnt_q == last_q);
  assign fetch_free_d = !fetch_pend_q && !(state_q != IDLE && cur_fetch_q && !done_d);
  assign lsq_free_d   = !lsq_pend_q && !(state_q != IDLE && !cur_fetch_q && !done_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_pend_q  <= 1'b0;
      fetch_addr_q  <= '0;
      lsq_pend_q    <= 1'b0;
      lsq_wr_q      <= 1'b0;
      lsq_addr_q    <= '0;
      lsq_wdata_q   <= '0;
      lsq_size_q    <= '0;
      cur_fetch_q   <= 1'b0;
      base_q        <= '0;
      wdata_q       <= '0;
      asm_q         <= '0;
      cnt_q         <= '0;
      last_q        <= '0;
      reissue_q     <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_dout_q    <= '0;
      mem_a_q       <= '0;
      fetch_ready_q <= 1'b0;
      lsq_ready_q   <= 1'b0;
      fetch_data_q  <= '0;
      lsq_data_q    <= '0;
    end else begin
      fetch_ready_q <= 1'b0;
      lsq_ready_q   <= 1'b0;
      if (!bus.ena) begin
        // Freeze: everything holds, the write strobe drops and the byte is replayed later.
        mem_wr_q <= 1'b0;
        if (state_q == RD || state_q == WR) reissue_q <= 1'b1;
      end else begin
        reissue_q <= 1'b0;
        if (bus.in_rollback) begin
          fetch_pend_q <= 1'b0;
        end else if (bus.in_fetch_ena && fetch_free_d) begin
          fetch_pend_q <= 1'b1;
          fetch_addr_q <= bus.in_fetch_addr;
        end
        if (bus.in_lsq_ena && lsq_free_d) begin
          lsq_pend_q  <= 1'b1;
          lsq_wr_q    <= bus.in_lsq_iswrite;
          lsq_addr_q  <= bus.in_lsq_addr;
          lsq_size_q  <= bus.in_lsq_size;
          lsq_wdata_q <= bus.in_lsq_write_data;
        end
        case (state_q)
          IDLE: begin
            if (lsq_pend_q) begin
              lsq_pend_q  <= 1'b0;
              cur_fetch_q <= 1'b0;
              base_q      <= lsq_addr_q;
              wdata_q     <= lsq_wdata_q;
              last_q      <= size_last(lsq_size_q);
              cnt_q       <= 2'd0;
              asm_q       <= '0;
              mem_a_q     <= lsq_addr_q;
              if (!lsq_wr_q) begin
                state_q  <= RD;
                mem_wr_q <= 1'b0;
              end else if (is_io(lsq_addr_q) && bus.io_buffer_full) begin
                state_q  <= WR_WAIT;
                mem_wr_q <= 1'b0;
              end else begin
                state_q    <= WR;
                mem_dout_q <= lsq_wdata_q[7:0];
                mem_wr_q   <= 1'b1;
              end
            end else if (fetch_pend_q && !bus.in_rollback) begin
              fetch_pend_q <= 1'b0;
              cur_fetch_q  <= 1'b1;
              base_q       <= fetch_addr_q;
              last_q       <= 2'd3;
              cnt_q        <= 2'd0;
              asm_q        <= '0;
              mem_a_q      <= fetch_addr_q;
              mem_wr_q     <= 1'b0;
              state_q      <= RD;
            end
          end
          RD: begin
            if (cur_fetch_q && bus.in_rollback) begin
              state_q <= IDLE;
              mem_a_q <= '0;
            end else if (reissue_q) begin
              mem_a_q <= cur_addr_d;
            end else if (cnt_q == last_q) begin
              state_q <= IDLE;
              mem_a_q <= '0;
              if (cur_fetch_q) begin
                fetch_ready_q <= 1'b1;
                fetch_data_q  <= asm_d;
              end else begin
                lsq_ready_q <= 1'b1;
                lsq_data_q  <= asm_d;
              end
            end else begin
              asm_q   <= asm_d;
              cnt_q   <= cnt_d;
              mem_a_q <= next_addr_d;
            end
          end
          WR: begin
            if (reissue_q) begin
              mem_a_q    <= cur_addr_d;
              mem_dout_q <= cur_byte_d;
              mem_wr_q   <= 1'b1;
            end else if (cnt_q == last_q) begin
              state_q     <= IDLE;
              mem_a_q     <= '0;
              mem_wr_q    <= 1'b0;
              lsq_ready_q <= 1'b1;
            end else if (is_io(next_addr_d) && bus.io_buffer_full) begin
              state_q  <= WR_WAIT;
              cnt_q    <= cnt_d;
              mem_a_q  <= next_addr_d;
              mem_wr_q <= 1'b0;
            end else begin
              cnt_q      <= cnt_d;
              mem_a_q    <= next_addr_d;
              mem_dout_q <= next_byte_d;
              mem_wr_q   <= 1'b1;
            end
          end
          WR_WAIT: begin
            if (!bus.io_buffer_full) begin
              state_q    <= WR;
              mem_a_q    <= cur_addr_d;
              mem_dout_q <= cur_byte_d;
              mem_wr_q   <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.out_fetch_ready = fetch_ready_q;
  assign bus.out_fetch_data  = fetch_data_q;
  assign bus.out_lsq_ready   = lsq_ready_q;
  assign bus.out_lsq_data    = lsq_data_q;
  assign bus.mem_dout        = mem_dout_q;
  assign bus.mem_a           = mem_a_q;
  assign bus.mem_wr          = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a small RAM model answers reads combinationally from
// the registered address; every result is compared against hand-computed values.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if bus();
  mem_ctrl #(.IO_ADDR_HI(2'b11)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] init_mem [0:1023];
  logic [7:0] ram      [0:1023];
  logic       ram_v    [0:1023];
  int          wr_cnt = 0;
  int          fr_cnt = 0;
  int          lr_cnt = 0;
  logic [31:0] last_wr_addr = '0;
  logic [7:0]  last_wr_data = '0;
  int          checks = 0;
  int          errors = 0;

  assign bus.mem_din = ram_v[bus.mem_a[9:0]] ? ram[bus.mem_a[9:0]] : init_mem[bus.mem_a[9:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram_v[i] <= 1'b0;
    end else if (bus.mem_wr) begin
      ram[bus.mem_a[9:0]]   <= bus.mem_dout;
      ram_v[bus.mem_a[9:0]] <= 1'b1;
    end
    if (bus.mem_wr) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= bus.mem_a;
      last_wr_data <= bus.mem_dout;
    end
    if (bus.out_fetch_ready) fr_cnt <= fr_cnt + 1;
    if (bus.out_lsq_ready)   lr_cnt <= lr_cnt + 1;
  end

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    mem_byte = ram_v[a[9:0]] ? ram[a[9:0]] : init_mem[a[9:0]];
  endfunction

  function automatic logic [31:0] rd32(input logic [31:0] a);
    rd32 = {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s got %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_req(input logic [31:0] a);
    bus.in_fetch_addr = a;
    bus.in_fetch_ena  = 1'b1;
    tick();
    bus.in_fetch_ena  = 1'b0;
  endtask

  task automatic lsq_req(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] d);
    bus.in_lsq_iswrite    = wr;
    bus.in_lsq_addr       = a;
    bus.in_lsq_size       = sz;
    bus.in_lsq_write_data = d;
    bus.in_lsq_ena        = 1'b1;
    tick();
    bus.in_lsq_ena        = 1'b0;
  endtask

  // Ticks until the chosen ready pulse shows; acc_t is the first tick mem_a showed acc_addr.
  task automatic wait_rdy(input string tag, input logic is_fetch, input logic [31:0] acc_addr,
                          output int acc_t, output int rdy_t);
    logic seen;
    seen  = 1'b0;
    acc_t = -1;
    rdy_t = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (acc_t < 0 && bus.mem_a == acc_addr) acc_t = i;
      if (is_fetch ? bus.out_fetch_ready : bus.out_lsq_ready) begin
        rdy_t = i;
        seen  = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_timeout"}, {31'b0, seen}, 32'd1);
  endtask

  task automatic wait_addr(input string tag, input logic [31:0] a);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.mem_a == a) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_timeout"}, {31'b0, seen}, 32'd1);
  endtask

  task automatic wait_wr(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.mem_wr) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_timeout"}, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    int acc, rdy, f0, l0, w0;
    rst                   = 1'b1;
    bus.ena               = 1'b1;
    bus.in_rollback       = 1'b0;
    bus.in_fetch_ena      = 1'b0;
    bus.in_fetch_addr     = '0;
    bus.in_lsq_ena        = 1'b0;
    bus.in_lsq_iswrite    = 1'b0;
    bus.in_lsq_addr       = '0;
    bus.in_lsq_size       = '0;
    bus.in_lsq_write_data = '0;
    bus.io_buffer_full    = 1'b0;
    for (int i = 0; i < 1024; i++) init_mem[i] = 8'h00;
    init_mem[10'h100] = 8'h13; init_mem[10'h101] = 8'h05;
    init_mem[10'h102] = 8'h00; init_mem[10'h103] = 8'h00;
    init_mem[10'h140] = 8'h93; init_mem[10'h141] = 8'h00;
    init_mem[10'h142] = 8'h10; init_mem[10'h143] = 8'h00;
    init_mem[10'h180] = 8'h11; init_mem[10'h181] = 8'h22;
    init_mem[10'h182] = 8'h33; init_mem[10'h183] = 8'h44;

    repeat (3) tick();
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_wr", {31'b0, bus.mem_wr}, 32'h0);
    chk("rst_fetch_ready", {31'b0, bus.out_fetch_ready}, 32'h0);
    chk("rst_lsq_ready", {31'b0, bus.out_lsq_ready}, 32'h0);
    chk("rst_fetch_data", bus.out_fetch_data, 32'h0);
    chk("rst_lsq_data", bus.out_lsq_data, 32'h0);
    rst = 1'b0;
    tick();

    // Plain fetch: four bytes, ready four cycles after the accept edge.
    f0 = fr_cnt;
    fetch_req(32'h100);
    wait_rdy("fetch", 1'b1, 32'h100, acc, rdy);
    chk("fetch_latency", rdy - acc, 32'd4);
    chk("fetch_data", bus.out_fetch_data, 32'h0000_0513);
    tick();
    chk("fetch_pulse_1cyc", {31'b0, bus.out_fetch_ready}, 32'h0);
    chk("fetch_data_hold", bus.out_fetch_data, 32'h0000_0513);
    chk("fetch_idle_a", bus.mem_a, 32'h0);
    chk("fetch_ready_count", fr_cnt - f0, 32'd1);

    // LSQ and fetch pulsed together: LSQ load goes first.
    f0 = fr_cnt;
    bus.in_fetch_addr = 32'h140;
    bus.in_fetch_ena  = 1'b1;
    lsq_req(1'b0, 32'h180, 3'd4, 32'h0);
    bus.in_fetch_ena  = 1'b0;
    wait_rdy("arb_lsq", 1'b0, 32'h180, acc, rdy);
    chk("arb_lsq_data", bus.out_lsq_data, 32'h4433_2211);
    chk("arb_fetch_not_yet", fr_cnt - f0, 32'd0);
    wait_rdy("arb_fetch", 1'b1, 32'h140, acc, rdy);
    chk("arb_fetch_data", bus.out_fetch_data, 32'h0010_0093);

    // Word store then narrow loads.
    w0 = wr_cnt;
    l0 = lr_cnt;
    lsq_req(1'b1, 32'h200, 3'd4, 32'hDEAD_BEEF);
    wait_rdy("sw", 1'b0, 32'h200, acc, rdy);
    chk("sw_wr_cycles", wr_cnt - w0, 32'd4);
    chk("sw_ram", rd32(32'h200), 32'hDEAD_BEEF);
    tick();
    chk("sw_wr_cleared", {31'b0, bus.mem_wr}, 32'h0);
    lsq_req(1'b0, 32'h202, 3'd2, 32'h0);
    wait_rdy("lh", 1'b0, 32'h202, acc, rdy);
    chk("lh_data", bus.out_lsq_data, 32'h0000_DEAD);
    lsq_req(1'b0, 32'h203, 3'd1, 32'h0);
    wait_rdy("lb", 1'b0, 32'h203, acc, rdy);
    chk("lb_data", bus.out_lsq_data, 32'h0000_00DE);
    lsq_req(1'b1, 32'h201, 3'd1, 32'hFFFF_FF77);
    wait_rdy("sb", 1'b0, 32'h201, acc, rdy);
    lsq_req(1'b0, 32'h200, 3'd3, 32'h0);
    wait_rdy("lsize3", 1'b0, 32'h200, acc, rdy);
    chk("size3_as_word", bus.out_lsq_data, 32'hDEAD_77EF);
    tick();
    chk("lsq_ready_total", lr_cnt - l0, 32'd5);

    // Second LSQ pulse while the first is still pending is ignored.
    l0 = lr_cnt;
    lsq_req(1'b0, 32'h200, 3'd1, 32'h0);
    lsq_req(1'b0, 32'h203, 3'd1, 32'h0);
    repeat (10) tick();
    chk("busy_pulse_ignored", lr_cnt - l0, 32'd1);
    chk("busy_first_data", bus.out_lsq_data, 32'h0000_00EF);

    // IO store stalled by a full UART buffer.
    w0 = wr_cnt;
    l0 = lr_cnt;
    bus.io_buffer_full = 1'b1;
    lsq_req(1'b1, 32'h0003_0000, 3'd1, 32'h0000_00A5);
    repeat (5) tick();
    chk("io_stall_no_wr", wr_cnt - w0, 32'd0);
    chk("io_stall_no_ready", lr_cnt - l0, 32'd0);
    bus.io_buffer_full = 1'b0;
    wait_rdy("io", 1'b0, 32'hFFFF_FFFF, acc, rdy);
    repeat (3) tick();
    chk("io_wr_once", wr_cnt - w0, 32'd1);
    chk("io_single_ready", lr_cnt - l0, 32'd1);
    chk("io_wr_addr", last_wr_addr, 32'h0003_0000);
    chk("io_wr_data", {24'b0, last_wr_data}, 32'h0000_00A5);

    // Rollback on the second fetch byte.
    f0 = fr_cnt;
    fetch_req(32'h100);
    wait_addr("rb_fetch", 32'h101);
    bus.in_rollback = 1'b1;
    tick();
    bus.in_rollback = 1'b0;
    chk("rb_idle_next", bus.mem_a, 32'h0);
    repeat (8) tick();
    chk("rb_no_fetch_ready", fr_cnt - f0, 32'd0);

    // Fetch pulse coincident with rollback is dropped.
    bus.in_rollback = 1'b1;
    fetch_req(32'h140);
    bus.in_rollback = 1'b0;
    repeat (8) tick();
    chk("rb_coincident_drop", fr_cnt - f0, 32'd0);

    // Store in flight during rollback still completes.
    l0 = lr_cnt;
    lsq_req(1'b1, 32'h210, 3'd4, 32'h1122_3344);
    wait_wr("rb_sw");
    bus.in_rollback = 1'b1;
    tick();
    bus.in_rollback = 1'b0;
    wait_rdy("rb_sw", 1'b0, 32'h210, acc, rdy);
    tick();
    chk("rb_sw_ram", rd32(32'h210), 32'h1122_3344);
    chk("rb_sw_ready", lr_cnt - l0, 32'd1);

    // Freeze for three cycles in the middle of a word load.
    lsq_req(1'b0, 32'h180, 3'd4, 32'h0);
    wait_addr("stall", 32'h181);
    bus.ena = 1'b0;
    repeat (3) tick();
    chk("stall_hold_a", bus.mem_a, 32'h181);
    chk("stall_wr_low", {31'b0, bus.mem_wr}, 32'h0);
    bus.ena = 1'b1;
    wait_rdy("stall", 1'b0, 32'h180, acc, rdy);
    chk("stall_data", bus.out_lsq_data, 32'h4433_2211);

    // Reset mid-fetch: no ready, outputs back to idle.
    f0 = fr_cnt;
    fetch_req(32'h100);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("midrst_mem_a", bus.mem_a, 32'h0);
    chk("midrst_fetch_data", bus.out_fetch_data, 32'h0);
    rst = 1'b0;
    repeat (8) tick();
    chk("midrst_no_ready", fr_cnt - f0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
